// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// Pure declarations and one combinational helper; no latency of its own.
// No flow control; consumers evaluate state_ctrl() every cycle.
package arm_ctrl_pkg;

  // Main FSM states, encoded in instruction order starting at FETCH = 0.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  // ALUControl encodings driven into the ALU.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // instr[27:26] instruction classes.
  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_B     = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  // Data-processing cmd field, instr[24:21].
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  // Result mux select.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU operand B select.
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Raw (ungated) control bundle produced by each state.
  typedef struct packed {
    logic       next_pc;
    logic       ir_write;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } raw_ctrl_t;

  // Per-state Moore control table; unlisted fields stay zero.
  function automatic raw_ctrl_t state_ctrl(input state_t st);
    raw_ctrl_t c;
    c = '0;
    case (st)
      FETCH: begin
        c.ir_write   = 1'b1;
        c.next_pc    = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
      end
      DECODE: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_FOUR;
        c.result_src = RES_ALURESULT;
      end
      MEMADR: begin
        c.alu_src_b = SRCB_IMM;
      end
      MEMREAD: begin
        c.adr_src = 1'b1;
      end
      MEMWB: begin
        c.result_src = RES_DATA;
        c.reg_w      = 1'b1;
      end
      MEMWRITE: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      EXECUTER: begin
        c.alu_op = 1'b1;
      end
      EXECUTEI: begin
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = 1'b1;
      end
      ALUWB: begin
        c.reg_w = 1'b1;
      end
      BRANCH: begin
        c.alu_src_b  = SRCB_IMM;
        c.result_src = RES_ALURESULT;
        c.branch     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/arm_alu_dec.sv
// ALU decoder: (ALUOp, Funct) -> ALUControl, FlagW, NoWrite. CMP support under ARM_MC_CTRL_CMP_EN.
// Purely combinational, zero cycles.
// No flow control; outputs follow inputs continuously.
module arm_alu_dec
  import arm_ctrl_pkg::*;
(
  input  logic       i_alu_op,
  input  logic [5:0] i_funct,
  output logic [1:0] o_alu_control,
  output logic [1:0] o_flag_w,
  output logic       o_no_write
);

  logic [3:0] w_cmd;
  logic       w_s;

  assign w_cmd = i_funct[4:1];
  assign w_s   = i_funct[0];

  // Map the data-processing cmd onto the ALU operation and flag write enables.
  always_comb begin
    o_alu_control = ALU_ADD;
    o_flag_w      = 2'b00;
    o_no_write    = 1'b0;
    if (i_alu_op) begin
      case (w_cmd)
        CMD_ADD: o_alu_control = ALU_ADD;
        CMD_SUB: o_alu_control = ALU_SUB;
        CMD_AND: o_alu_control = ALU_AND;
        CMD_ORR: o_alu_control = ALU_ORR;
        default: o_alu_control = ALU_ADD;
      endcase
      // N,Z follow S for every op; C,V only matter for arithmetic ops.
      o_flag_w = {w_s, w_s & ((w_cmd == CMD_ADD) | (w_cmd == CMD_SUB))};
`ifdef ARM_MC_CTRL_CMP_EN
      // CMP is a flag-setting subtract whether or not S is encoded.
      if (w_cmd == CMD_CMP) begin
        o_alu_control = ALU_SUB;
        o_flag_w      = 2'b11;
      end
`endif
    end
`ifdef ARM_MC_CTRL_CMP_EN
    // Independent of ALUOp so it is still valid in the write-back state.
    o_no_write = (w_cmd == CMD_CMP);
`endif
  end

endmodule

// File: rtl/arm_mc_ctrl.sv
// Multicycle ARM control unit: Moore FSM (fetch/decode/execute/write-back) plus condition gating.
// Outputs combinational from registered state; LDR 5, STR 4, DP 4, B 3, undefined 2 cycles.
// No backpressure; one state per clock. Optional CMP decode via ARM_MC_CTRL_CMP_EN.
module arm_mc_ctrl
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       CondEx,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW
);

  state_t     r_state;
  state_t     w_next;
  raw_ctrl_t  w_raw;
  logic [1:0] w_dec_alu_control;
  logic [1:0] w_dec_flag_w;
  logic       w_dec_no_write;
  logic       w_no_write;
  logic       w_pcs;

  // State register; reset forces FETCH immediately, even mid-instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; Op is only consulted in DECODE, Funct[0] in MEMADR.
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:  w_next = DECODE;
      DECODE: begin
        case (Op)
          OP_DP:    w_next = Funct[5] ? EXECUTEI : EXECUTER;
          OP_MEM:   w_next = MEMADR;
          OP_B:     w_next = BRANCH;
          OP_UNDEF: w_next = FETCH;
          default:  w_next = FETCH;
        endcase
      end
      MEMADR:   w_next = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  w_next = MEMWB;
      MEMWB:    w_next = FETCH;
      MEMWRITE: w_next = FETCH;
      EXECUTER: w_next = ALUWB;
      EXECUTEI: w_next = ALUWB;
      ALUWB:    w_next = FETCH;
      BRANCH:   w_next = FETCH;
      default:  w_next = FETCH;
    endcase
  end

  assign w_raw = state_ctrl(r_state);

  arm_alu_dec u_alu_dec (
    .i_alu_op      (w_raw.alu_op),
    .i_funct       (Funct),
    .o_alu_control (w_dec_alu_control),
    .o_flag_w      (w_dec_flag_w),
    .o_no_write    (w_dec_no_write)
  );

  // NoWrite only suppresses the data-processing write-back, never a load.
  assign w_no_write = w_dec_no_write & (r_state == ALUWB);

  // A register write to R15 is really a PC write.
  assign w_pcs = w_raw.reg_w & (Rd == 4'hF);

  // Gate enables with the condition result; hold all enables low during reset.
  always_comb begin
    PCWrite    = ~reset & (w_raw.next_pc | ((w_raw.branch | w_pcs) & CondEx));
    IRWrite    = ~reset & w_raw.ir_write;
    RegWrite   = ~reset & w_raw.reg_w & CondEx & ~w_pcs & ~w_no_write;
    MemWrite   = ~reset & w_raw.mem_w & CondEx;
    FlagW      = (reset | ~CondEx) ? 2'b00 : w_dec_flag_w;
    AdrSrc     = w_raw.adr_src;
    ALUSrcA    = w_raw.alu_src_a;
    ALUSrcB    = w_raw.alu_src_b;
    ResultSrc  = w_raw.result_src;
    ALUControl = w_dec_alu_control;
  end

endmodule

// File: tb/tb_arm_mc_ctrl.sv
// Scoreboard bench for arm_mc_ctrl: expected per-cycle control vectors are queued as stimulus is driven.
// Each cycle is checked on the falling edge against an independently written control model.
// Honours ARM_MC_CTRL_CMP_EN to select the CMP expectations.
module tb_arm_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       CondEx;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
  logic [13:0] act;

  int n_vec = 0;
  int n_err = 0;

  logic [13:0] exp_q[$];
  string       tag_q[$];

  localparam int T_RST = 0, T_F = 1, T_D = 2, T_MA = 3, T_MR = 4, T_MWB = 5;
  localparam int T_MW = 6, T_ER = 7, T_EI = 8, T_AW = 9, T_BR = 10;

  arm_mc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .CondEx     (CondEx),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .FlagW      (FlagW)
  );

  always #5 clk = ~clk;

  assign act = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ALUControl, FlagW};

  task automatic chk(input string tag, input logic [13:0] got, input logic [13:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b want %b (pcw irw rw mw adr asa asb rs alc fw)", tag, got, want);
    end
  endtask

  function automatic string st_name(input int s);
    case (s)
      T_RST:   return "RESET";
      T_F:     return "FETCH";
      T_D:     return "DECODE";
      T_MA:    return "MEMADR";
      T_MR:    return "MEMREAD";
      T_MWB:   return "MEMWB";
      T_MW:    return "MEMWRITE";
      T_ER:    return "EXECUTER";
      T_EI:    return "EXECUTEI";
      T_AW:    return "ALUWB";
      T_BR:    return "BRANCH";
      default: return "?";
    endcase
  endfunction

  // Expected output vector for a given state, instruction fields and condition.
  function automatic logic [13:0] model(input int s, input logic [5:0] f,
                                        input logic [3:0] rd, input logic cx);
    logic       pcw, irw, rw, mw, adr, asa;
    logic [1:0] asb, rs, alc, fw;
    logic [3:0] cmd;
    logic       sb, pc_dst;
    pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0; asa = 0;
    asb = 2'b00; rs = 2'b00; alc = 2'b00; fw = 2'b00;
    cmd = f[4:1];
    sb = f[0];
    pc_dst = (rd == 4'hF);
    case (s)
      T_RST: begin asa = 1; asb = 2'b10; rs = 2'b10; end
      T_F:   begin pcw = 1; irw = 1; asa = 1; asb = 2'b10; rs = 2'b10; end
      T_D:   begin asa = 1; asb = 2'b10; rs = 2'b10; end
      T_MA:  asb = 2'b01;
      T_MR:  adr = 1;
      T_MWB: begin rs = 2'b01; rw = cx & !pc_dst; pcw = cx & pc_dst; end
      T_MW:  begin adr = 1; mw = cx; end
      T_ER, T_EI: begin
        if (s == T_EI) asb = 2'b01;
        case (cmd)
          4'b0100: alc = 2'b00;
          4'b0010: alc = 2'b01;
          4'b0000: alc = 2'b10;
          4'b1100: alc = 2'b11;
          default: alc = 2'b00;
        endcase
        fw = {sb, sb & (cmd == 4'b0100 || cmd == 4'b0010)};
`ifdef ARM_MC_CTRL_CMP_EN
        if (cmd == 4'b1010) begin alc = 2'b01; fw = 2'b11; end
`endif
        fw = fw & {2{cx}};
      end
      T_AW: begin
        rw = cx & !pc_dst;
`ifdef ARM_MC_CTRL_CMP_EN
        if (cmd == 4'b1010) rw = 0;
`endif
        pcw = cx & pc_dst;
      end
      T_BR: begin asb = 2'b01; rs = 2'b10; pcw = cx; end
      default: ;
    endcase
    return {pcw, irw, rw, mw, adr, asa, asb, rs, alc, fw};
  endfunction

  // One clock: queue the expectation, compare on the falling edge, move past the next rising edge.
  task automatic step(input string nm, input int s);
    exp_q.push_back(model(s, Funct, Rd, CondEx));
    tag_q.push_back({nm, ".", st_name(s)});
    @(negedge clk);
    chk(tag_q.pop_front(), act, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction; abort_at >= 0 pulses reset at that cycle instead of completing it.
  task automatic run_instr(input string nm, input logic [1:0] op, input logic [5:0] f,
                           input logic [3:0] rd, input logic cx, input int abort_at);
    int seq[$];
    Op = op; Funct = f; Rd = rd; CondEx = cx;
    seq.push_back(T_F);
    seq.push_back(T_D);
    case (op)
      2'b00: begin seq.push_back(f[5] ? T_EI : T_ER); seq.push_back(T_AW); end
      2'b01: begin
        seq.push_back(T_MA);
        if (f[0]) begin seq.push_back(T_MR); seq.push_back(T_MWB); end
        else seq.push_back(T_MW);
      end
      2'b10: seq.push_back(T_BR);
      default: ;
    endcase
    foreach (seq[i]) begin
      if (i == abort_at) begin
        reset = 1'b1;
        step({nm, "_rst"}, T_RST);
        step({nm, "_rst"}, T_RST);
        reset = 1'b0;
        return;
      end
      step(nm, seq[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; Op = 2'b00; Funct = 6'd0; Rd = 4'd0; CondEx = 1'b1;
    #1;
    step("por", T_RST);
    step("por", T_RST);
    reset = 1'b0;

    run_instr("ldr",      2'b01, 6'b011001, 4'd3,  1'b1, -1);
    run_instr("ldr_abrt", 2'b01, 6'b011001, 4'd3,  1'b1, 3);
    run_instr("ldr_post", 2'b01, 6'b011001, 4'd4,  1'b1, -1);
    run_instr("str_nc",   2'b01, 6'b011000, 4'd2,  1'b0, -1);
    run_instr("str",      2'b01, 6'b011000, 4'd2,  1'b1, -1);
    run_instr("subs",     2'b00, 6'b000101, 4'd1,  1'b1, -1);
    run_instr("orrs_reg", 2'b00, 6'b011001, 4'd1,  1'b1, -1);
    run_instr("orrs_imm", 2'b00, 6'b111001, 4'd1,  1'b1, -1);
    run_instr("add_pc",   2'b00, 6'b001000, 4'hF,  1'b1, -1);
    run_instr("ands_nc",  2'b00, 6'b000001, 4'd5,  1'b0, -1);
    run_instr("adds_imm", 2'b00, 6'b101001, 4'd6,  1'b1, -1);
    run_instr("eors",     2'b00, 6'b000011, 4'd7,  1'b1, -1);
    run_instr("b_taken",  2'b10, 6'b100000, 4'd0,  1'b1, -1);
    run_instr("b_nt",     2'b10, 6'b100000, 4'd0,  1'b0, -1);
    run_instr("undef",    2'b11, 6'b000000, 4'd0,  1'b1, -1);
    run_instr("cmp",      2'b00, 6'b010101, 4'd0,  1'b1, -1);
    run_instr("ldr_pc",   2'b01, 6'b011001, 4'hF,  1'b1, -1);
    run_instr("dp_mid_rst", 2'b00, 6'b000101, 4'd1, 1'b1, 2);
    run_instr("undef_end", 2'b11, 6'b000000, 4'd0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
